uart_tx_arbiter: RTL and testbench

- Shares one TxControl transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Latches the winning byte and drives TxControl's active-low write strobe (n_wr_in) for WR_PULSE clocks.
- Then tracks TxControl's tx_rdy_out handshake (falls when the byte is accepted, rises when the frame is done) before the next grant.
- Sits between local byte producers (command/status/debug sources) and TxControl in the UART library.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one TxControl among NUM_REQ byte sources.
// Define UART_ARB_LOCK_EN to add lock_in, which keeps multi-byte packets unbroken.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GRANT_W      = 2,
    parameter int WR_PULSE     = 5,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 clk_in,
    input  logic                 n_reset_in,
    input  logic                 enable_in,
    input  logic [NUM_REQ-1:0]   req_in,
    input  logic [NUM_REQ*8-1:0] data_in,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   lock_in,
`endif
    output logic [NUM_REQ-1:0]   ack_out,
    output logic [GRANT_W-1:0]   grant_out,
    output logic                 busy_out,
    output logic                 err_out,
    output logic [7:0]           tx_data_out,
    output logic                 tx_n_wr_out,
    input  logic                 tx_rdy_in
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [GRANT_W-1:0]   ptr_q, ptr_d;
    logic [GRANT_W-1:0]   grant_d;
    logic [7:0]           data_d;
    logic [NUM_REQ-1:0]   ack_d;
    logic                 n_wr_d;
    logic                 busy_d;
    logic                 err_d;
    logic                 any_req;
    logic                 hi_found;
    logic [GRANT_W-1:0]   hi_idx, lo_idx, win;
    logic [7:0]           win_byte;

    assign any_req = |req_in;

    // Lowest set bit above the pointer wins, else lowest set bit overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_in[j]) begin
                if (j > int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = GRANT_W'(j);
                end else begin
                    lo_idx = GRANT_W'(j);
                end
            end
        end
        win = hi_found ? hi_idx : lo_idx;
`ifdef UART_ARB_LOCK_EN
        for (int j = 0; j < NUM_REQ; j++) begin
            if (GRANT_W'(j) == grant_out && req_in[j] && lock_in[j])
                win = GRANT_W'(j);
        end
`endif
        win_byte = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (GRANT_W'(j) == win)
                win_byte = data_in[8*j +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_out;
        data_d  = tx_data_out;
        n_wr_d  = tx_n_wr_out;
        ack_d   = '0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_in && tx_rdy_in && any_req) begin
                    state_d = WRITE;
                    cnt_d   = 8'(WR_PULSE - 1);
                    ptr_d   = win;
                    grant_d = win;
                    data_d  = win_byte;
                    n_wr_d  = 1'b0;
                    for (int j = 0; j < NUM_REQ; j++)
                        ack_d[j] = (GRANT_W'(j) == win);
                end
            end
            WRITE: begin
                if (cnt_q == 8'd0) begin
                    n_wr_d  = 1'b1;
                    state_d = WAIT_BUSY;
                    cnt_d   = 8'(BUSY_TIMEOUT);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT_BUSY: begin
                if (!tx_rdy_in) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q <= 8'd1) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT_DONE: begin
                if (tx_rdy_in)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= GRANT_W'(NUM_REQ - 1);
            grant_out   <= '0;
            tx_data_out <= '0;
            tx_n_wr_out <= 1'b1;
            ack_out     <= '0;
            busy_out    <= 1'b0;
            err_out     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_out   <= grant_d;
            tx_data_out <= data_d;
            tx_n_wr_out <= n_wr_d;
            ack_out     <= ack_d;
            busy_out    <= busy_d;
            err_out     <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a TxControl handshake model.
// Round-robin expectations come from a queue-free arithmetic reference.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int GW = 2;
    localparam int WP = 5;
    localparam int BT = 16;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic           enable = 1'b0;
    logic           tx_rdy = 1'b1;
    logic [N-1:0]   req    = '0;
    logic [N*8-1:0] data   = '0;
`ifdef UART_ARB_LOCK_EN
    logic [N-1:0]   lock   = '0;
`endif
    logic [N-1:0]   ack;
    logic [GW-1:0]  grant;
    logic           busy;
    logic           err;
    logic [7:0]     tx_data;
    logic           n_wr;

    logic [7:0]     bytes [N];
    int             errors = 0;
    int             checks = 0;
    int             ptr_m  = N - 1;

    bit             stuck    = 1'b0;
    bit             hold_low = 1'b0;
    int             drop_dly = 2;
    int             busy_len = 200;
    int             phase    = 0;
    int             mcnt     = 0;

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .GRANT_W(GW),
        .WR_PULSE(WP),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk_in(clk),
        .n_reset_in(rst_n),
        .enable_in(enable),
        .req_in(req),
        .data_in(data),
`ifdef UART_ARB_LOCK_EN
        .lock_in(lock),
`endif
        .ack_out(ack),
        .grant_out(grant),
        .busy_out(busy),
        .err_out(err),
        .tx_data_out(tx_data),
        .tx_n_wr_out(n_wr),
        .tx_rdy_in(tx_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // TxControl: ready drops drop_dly clocks after the strobe, returns busy_len later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 0;
            tx_rdy <= 1'b1;
        end else if (hold_low) begin
            phase  <= 0;
            tx_rdy <= 1'b0;
        end else if (stuck) begin
            phase  <= 0;
            tx_rdy <= 1'b1;
        end else begin
            case (phase)
                0: begin
                    tx_rdy <= 1'b1;
                    if (!n_wr) begin
                        phase <= 1;
                        mcnt  <= drop_dly;
                    end
                end
                1: begin
                    if (mcnt <= 1) begin
                        tx_rdy <= 1'b0;
                        phase  <= 2;
                        mcnt   <= busy_len;
                    end else begin
                        mcnt <= mcnt - 1;
                    end
                end
                default: begin
                    if (mcnt <= 1) begin
                        tx_rdy <= 1'b1;
                        phase  <= 0;
                    end else begin
                        mcnt <= mcnt - 1;
                    end
                end
            endcase
        end
    end

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] s;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (p + i) % N;
            s = r >> k;
            if (s[0]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        return N'(1) << k;
    endfunction

    task automatic load_bytes();
        data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ptr_m = N - 1;
        @(negedge clk);
    endtask

    // Measures one transaction; callers do the comparisons.
    task automatic run_txn(
        input  bit            drop,
        output bit            timed_out,
        output logic [N-1:0]  ack1,
        output logic [GW-1:0] g,
        output logic [7:0]    d,
        output logic [N-1:0]  ack2,
        output int            low_len,
        output bit            d_stable,
        output int            err_dist,
        output int            idle_lag
    );
        int t;
        int since;
        int rdy_ret;
        bit seen_low;
        timed_out = 1'b0;
        ack1 = '0; g = '0; d = '0; ack2 = '0;
        low_len = 0; d_stable = 1'b1; err_dist = -1; idle_lag = -1;
        seen_low = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ack == '0 && t < 300);
        if (ack == '0) begin
            timed_out = 1'b1;
            return;
        end
        ack1 = ack;
        g    = grant;
        d    = tx_data;
        if (drop) req = req & ~ack;
        while (n_wr == 1'b0 && low_len < 300) begin
            low_len++;
            if (!tx_rdy) seen_low = 1'b1;
            @(negedge clk);
            if (low_len == 1) ack2 = ack;
            if (tx_data !== d) d_stable = 1'b0;
        end
        since   = 0;
        rdy_ret = -1;
        while (busy === 1'b1 && since < 1000) begin
            if (!tx_rdy) seen_low = 1'b1;
            else if (seen_low && rdy_ret < 0) rdy_ret = since;
            @(negedge clk);
            since++;
            if (tx_data !== d) d_stable = 1'b0;
            if (err === 1'b1 && err_dist < 0) err_dist = since;
        end
        if (busy !== 1'b0) timed_out = 1'b1;
        if (rdy_ret >= 0) idle_lag = since - rdy_ret;
    endtask

    task automatic test_reset();
        bit to; logic [N-1:0] a1, a2; logic [GW-1:0] g; logic [7:0] d;
        int ll, ed, il; bit ds; int t;
        repeat (3) @(negedge clk);
        checks++;
        if (n_wr !== 1'b1) begin errors++; $display("FAIL reset_n_wr got=%b want=1", n_wr); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (ack !== '0) begin errors++; $display("FAIL reset_ack got=%b want=0", ack); end
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL reset_grant got=%0d want=0", grant); end
        checks++;
        if (err !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_err_data got=%b/%h want=0/00", err, tx_data);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < N; i++) bytes[i] = 8'($urandom);
        load_bytes();
        req = 4'b1111;
        t = 0;
        do begin @(negedge clk); t++; end while (ack == '0 && t < 50);
        checks++;
        if (ack == '0) begin errors++; $display("FAIL reset_first_ack got=0 want=nonzero"); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (n_wr !== 1'b1 || busy !== 1'b0 || ack !== '0 || grant !== '0) begin
            errors++;
            $display("FAIL reset_abort got n_wr=%b busy=%b ack=%b grant=%0d want 1/0/0/0",
                     n_wr, busy, ack, grant);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        ptr_m = N - 1;
        run_txn(1'b0, to, a1, g, d, a2, ll, ds, ed, il);
        req = '0;
        checks++;
        if (to || g !== 2'd0 || a1 !== 4'b0001) begin
            errors++; $display("FAIL reset_release_grant got=%0d ack=%b to=%0b want=0", g, a1, to);
        end
        ptr_m = 0;
    endtask

    task automatic test_single();
        bit to; logic [N-1:0] a1, a2; logic [GW-1:0] g; logic [7:0] d;
        int ll, ed, il, exp; bit ds;
        busy_len = 200;
        drop_dly = 2;
        bytes[2] = 8'hA5;
        load_bytes();
        req = 4'b0100;
        exp = rr_pick(req, ptr_m);
        run_txn(1'b1, to, a1, g, d, a2, ll, ds, ed, il);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout got=timeout want=done"); end
        checks++;
        if (a1 !== onehot(exp) || a2 !== '0) begin
            errors++; $display("FAIL single_ack got=%b,%b want=%b,0000", a1, a2, onehot(exp));
        end
        checks++;
        if (d !== 8'hA5 || g !== GW'(exp)) begin
            errors++; $display("FAIL single_data got=%h/%0d want=a5/%0d", d, g, exp);
        end
        checks++;
        if (ll != WP) begin errors++; $display("FAIL single_low_len got=%0d want=%0d", ll, WP); end
        checks++;
        if (!ds || tx_data !== 8'hA5) begin
            errors++; $display("FAIL single_stable got=%h want=a5", tx_data);
        end
        checks++;
        if (ed != -1 || il != 1) begin
            errors++; $display("FAIL single_busy got err=%0d lag=%0d want -1/1", ed, il);
        end
        ptr_m = exp;
    endtask

    task automatic test_round_robin();
        bit to; logic [N-1:0] a1, a2; logic [GW-1:0] g; logic [7:0] d;
        int ll, ed, il, exp; bit ds;
        int served [N];
        do_reset();
        busy_len = 20;
        for (int i = 0; i < N; i++) begin
            bytes[i] = 8'h10 + 8'(i);
            served[i] = 0;
        end
        load_bytes();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp = rr_pick(req, ptr_m);
            run_txn(1'b0, to, a1, g, d, a2, ll, ds, ed, il);
            checks++;
            if (to || g !== GW'(exp) || d !== bytes[2'(exp)] || a1 !== onehot(exp)) begin
                errors++;
                $display("FAIL rr_grant n=%0d got=%0d/%h want=%0d/%h", n, g, d, exp, bytes[2'(exp)]);
            end
            if (n < N) served[2'(g)]++;
            ptr_m = exp;
        end
        req = '0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (served[i] != 1) begin
                errors++; $display("FAIL rr_fair req=%0d got=%0d want=1", i, served[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to; logic [N-1:0] a1, a2; logic [GW-1:0] g; logic [7:0] d;
        int ll, ed, il, exp; bit ds;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < N; i++) bytes[i] = 8'($urandom);
            load_bytes();
            drop_dly = $urandom_range(1, 4);
            busy_len = $urandom_range(8, 40);
            req = 4'($urandom_range(1, 15));
            exp = rr_pick(req, ptr_m);
            run_txn(1'b1, to, a1, g, d, a2, ll, ds, ed, il);
            checks++;
            if (to || g !== GW'(exp) || d !== bytes[2'(exp)] || a1 !== onehot(exp)) begin
                errors++;
                $display("FAIL rand_grant n=%0d got=%0d/%h want=%0d/%h", n, g, d, exp, bytes[2'(exp)]);
            end
            checks++;
            if (ll != WP || !ds || ed != -1 || il != 1) begin
                errors++;
                $display("FAIL rand_timing n=%0d got low=%0d err=%0d lag=%0d want %0d/-1/1",
                         n, ll, ed, il, WP);
            end
            ptr_m = exp;
        end
        req = '0;
    endtask

    task automatic test_timeout();
        bit to; logic [N-1:0] a1, a2; logic [GW-1:0] g; logic [7:0] d;
        int ll, ed, il, exp; bit ds;
        stuck = 1'b1;
        req = 4'b0110;
        for (int n = 0; n < 2; n++) begin
            exp = rr_pick(req, ptr_m);
            run_txn(1'b1, to, a1, g, d, a2, ll, ds, ed, il);
            checks++;
            if (to || g !== GW'(exp)) begin
                errors++; $display("FAIL timeout_grant n=%0d got=%0d want=%0d", n, g, exp);
            end
            checks++;
            if (ed != BT) begin
                errors++; $display("FAIL timeout_err_dist n=%0d got=%0d want=%0d", n, ed, BT);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_pulse got=1 want=0"); end
            ptr_m = exp;
        end
        req = '0;
        stuck = 1'b0;
    endtask

    task automatic test_rdy_block();
        bit to; logic [N-1:0] a1, a2; logic [GW-1:0] g; logic [7:0] d;
        int ll, ed, il, exp, strobes; bit ds;
        hold_low = 1'b1;
        @(negedge clk);
        req = 4'b0001;
        strobes = 0;
        repeat (30) begin
            @(negedge clk);
            if (n_wr == 1'b0 || ack != '0) strobes++;
        end
        checks++;
        if (strobes != 0) begin errors++; $display("FAIL rdy_block got=%0d want=0", strobes); end
        hold_low = 1'b0;
        exp = rr_pick(req, ptr_m);
        run_txn(1'b1, to, a1, g, d, a2, ll, ds, ed, il);
        checks++;
        if (to || g !== GW'(exp)) begin
            errors++; $display("FAIL rdy_release got=%0d want=%0d", g, exp);
        end
        ptr_m = exp;
        req = '0;
    endtask

    task automatic test_enable();
        int strobes, exp, t;
        busy_len = 40;
        drop_dly = 2;
        enable = 1'b0;
        req = 4'b0011;
        strobes = 0;
        repeat (100) begin
            @(negedge clk);
            if (n_wr == 1'b0 || ack != '0) strobes++;
        end
        checks++;
        if (strobes != 0) begin errors++; $display("FAIL enable_low got=%0d want=0", strobes); end
        exp = rr_pick(req, ptr_m);
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== onehot(exp) || grant !== GW'(exp)) begin
            errors++; $display("FAIL enable_rise got=%b/%0d want=%b/%0d", ack, grant, onehot(exp), exp);
        end
        ptr_m = exp;
        req = req & ~onehot(exp);
        t = 0;
        while (busy && t < 500) begin @(negedge clk); t++; end
        exp = rr_pick(req, ptr_m);
        t = 0;
        do begin @(negedge clk); t++; end while (ack == '0 && t < 50);
        checks++;
        if (ack !== onehot(exp)) begin
            errors++; $display("FAIL enable_second got=%b want=%b", ack, onehot(exp));
        end
        ptr_m = exp;
        while (n_wr == 1'b0 && t < 100) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        enable = 1'b0;
        req = 4'b0011;
        t = 0;
        while (busy && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL enable_complete got busy=%b err=%b want 0/0", busy, err);
        end
        strobes = 0;
        repeat (60) begin
            @(negedge clk);
            if (n_wr == 1'b0 || ack != '0) strobes++;
        end
        checks++;
        if (strobes != 0) begin errors++; $display("FAIL enable_hold got=%0d want=0", strobes); end
        req = '0;
        enable = 1'b1;
    endtask

`ifdef UART_ARB_LOCK_EN
    task automatic test_lock();
        bit to; logic [N-1:0] a1, a2; logic [GW-1:0] g; logic [7:0] d;
        int ll, ed, il, exp, last; bit ds;
        do_reset();
        busy_len = 20;
        req = 4'b0011;
        lock = 4'b0001;
        last = 0;
        for (int n = 0; n < 4; n++) begin
            if (n == 3) lock = '0;
            exp = rr_pick(req, ptr_m);
            if (n > 0 && ((lock >> last) & req & 4'b0001 << 0) != 0 && (req >> last) != 0)
                exp = ((lock & req) >> last) & 1 ? last : exp;
            run_txn(1'b0, to, a1, g, d, a2, ll, ds, ed, il);
            checks++;
            if (to || g !== GW'(n < 3 ? 0 : 1) || g !== GW'(exp)) begin
                errors++; $display("FAIL lock_grant n=%0d got=%0d want=%0d", n, g, n < 3 ? 0 : 1);
            end
            ptr_m = exp;
            last = exp;
        end
        req = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_random();
        test_timeout();
        test_rdy_block();
        test_enable();
`ifdef UART_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
